// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SCAN       = 2'd0;
  localparam state_t PRESS_DB   = 2'd1;
  localparam state_t HELD       = 2'd2;
  localparam state_t RELEASE_DB = 2'd3;

  // Column drive loaded at reset; a single low bit that rotates left.
  localparam logic [3:0] COL_INIT = 4'b1110;

  // Key codes are 4*row + col.
  localparam logic [3:0] KEY_RESET   = 4'h0;
  localparam logic [3:0] KEY_SPECIAL = 4'hE;

  // Index of the lowest active-low bit; callers only use it when a bit is low.
  function automatic logic [1:0] lowestLow(input logic [3:0] v);
    logic [1:0] idx;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] keyCode(input logic [1:0] rowIdx, input logic [1:0] colIdx);
    return {rowIdx, colIdx};
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Parameterised two-flop synchronizer, resets to all-ones (idle keypad rows).
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with press/release debounce.
// Outputs are all registered; the captured row alone governs release.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       pre
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE - 1);

  logic [3:0]    rs;
  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [MW-1:0] match_q, match_d;
  logic [1:0]    rowSel_q, rowSel_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    key_q, key_d;
  logic          pre_q, pre_d;
  logic          sample;
  logic [1:0]    colIdx;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (row),
    .q_o   (rs)
  );

  assign sample = (dwell_q == DWELL_LAST);

  // Column index of the single low drive bit.
  always_comb begin
    colIdx = 2'd0;
    if (!col_q[1]) colIdx = 2'd1;
    if (!col_q[2]) colIdx = 2'd2;
    if (!col_q[3]) colIdx = 2'd3;
  end

  // Next-state logic: every decision is taken on a sample clock.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    rowSel_d = rowSel_q;
    col_d    = col_q;
    key_d    = key_q;
    pre_d    = pre_q;
    dwell_d  = sample ? '0 : dwell_q + 1'b1;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (rs == 4'b1111) begin
            col_d = {col_q[2:0], col_q[3]};
          end else begin
            rowSel_d = lowestLow(rs);
            if (DEBOUNCE == 1) begin
              key_d   = keyCode(lowestLow(rs), colIdx);
              pre_d   = 1'b1;
              state_d = HELD;
            end else begin
              match_d = MW'(1);
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (!rs[rowSel_q]) begin
            if (match_q == MATCH_LAST) begin
              key_d   = keyCode(rowSel_q, colIdx);
              pre_d   = 1'b1;
              state_d = HELD;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            state_d = SCAN;
          end
        end
        HELD: begin
          if (rs[rowSel_q]) begin
            if (DEBOUNCE == 1) begin
              pre_d   = 1'b0;
              col_d   = {col_q[2:0], col_q[3]};
              state_d = SCAN;
            end else begin
              match_d = MW'(1);
              state_d = RELEASE_DB;
            end
          end
        end
        RELEASE_DB: begin
          if (rs[rowSel_q]) begin
            if (match_q == MATCH_LAST) begin
              pre_d   = 1'b0;
              col_d   = {col_q[2:0], col_q[3]};
              state_d = SCAN;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SCAN;
      dwell_q  <= '0;
      match_q  <= '0;
      rowSel_q <= 2'd0;
      col_q    <= COL_INIT;
      key_q    <= KEY_RESET;
      pre_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      match_q  <= match_d;
      rowSel_q <= rowSel_d;
      col_q    <= col_d;
      key_q    <= key_d;
      pre_q    <= pre_d;
    end
  end

  assign col = col_q;
  assign key = key_q;
  assign pre = pre_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3.
// The keypad is modelled as a set of pressed switches; expected timing is
// derived from sample instants (every 4th clock after reset release).
module tb_keypad_scan;

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        pre;
  logic [15:0] pressed;
  logic [3:0]  lastKey;
  int          passCount;
  int          totalCount;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .row   (row),
    .col   (col),
    .key   (key),
    .pre   (pre)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed switch pulls its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] colDrive(input int c);
    logic [3:0] m;
    m = 4'b0001 << c;
    return ~m;
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  // Wait until the scan moves onto column c; that move lands on a sample clock.
  task automatic waitColEntry(input int c, input string tag);
    logic [3:0] prev;
    logic       found;
    found = 1'b0;
    prev  = col;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (col == colDrive(c) && prev != colDrive(c)) found = 1'b1;
      prev = col;
    end
    checkOutput({tag, "_colEntry"}, {3'b000, found}, 4'h1);
  endtask

  // Tick 0 is a sample instant with the keys already applied. A change made
  // at tick R is first seen by the sample at the first multiple of 4 >= R+3;
  // a press or release is accepted two samples later.
  task automatic trackPress(input string tag, input logic [3:0] expKey, input int relTick,
                            input logic [15:0] extraKeys, input int extraTick, input int c);
    int   t;
    int   s;
    int   riseTick;
    int   fallTick;
    logic expPre;
    t        = 0;
    riseTick = 12;
    fallTick = 1000;
    while (t < fallTick + 2 && t < 300) begin
      @(negedge clk);
      t++;
      expPre = (t >= riseTick) && (t < fallTick);
      checkOutput({tag, "_pre"}, {3'b000, pre}, {3'b000, expPre});
      checkOutput({tag, "_key"}, key, (t >= riseTick) ? expKey : lastKey);
      if (t == fallTick)     checkOutput({tag, "_colNext"}, col, colDrive((c + 1) % 4));
      else if (t < fallTick) checkOutput({tag, "_colFrozen"}, col, colDrive(c));
      if (t == extraTick) applyStimulus(pressed | extraKeys);
      if (t == relTick) begin
        applyStimulus('0);
        s = relTick + 3;
        while (s % 4 != 0) s++;
        fallTick = s + 8;
      end
    end
    lastKey = expKey;
  endtask

  // Assert reset between clock edges, check outputs at once, release on a falling edge.
  task automatic midReset(input string tag);
    #2 reset = 1'b0;
    #1;
    checkOutput({tag, "_col"}, col, 4'b1110);
    checkOutput({tag, "_key"}, key, 4'h0);
    checkOutput({tag, "_pre"}, {3'b000, pre}, 4'h0);
    lastKey = 4'h0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int k;
    int rel;
    logic [15:0] m;
    passCount  = 0;
    totalCount = 0;
    lastKey    = 4'h0;
    pressed    = '0;
    reset      = 1'b0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    checkOutput("rst_col", col, 4'b1110);
    checkOutput("rst_key", key, 4'h0);
    checkOutput("rst_pre", {3'b000, pre}, 4'h0);
    reset = 1'b1;

    // Idle scan: column advances every 4 clocks.
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      checkOutput("idle_col", col, colDrive((t / 4) % 4));
      checkOutput("idle_pre", {3'b000, pre}, 4'h0);
    end

    // Clean press at row 2, col 1 held 40 clocks.
    waitColEntry(1, "clean");
    applyStimulus(16'h0200);
    trackPress("clean", 4'h9, 40, '0, -1, 1);

    // Bounce at row 0, col 3: one sample low, one sample high, five times.
    waitColEntry(3, "bounce");
    applyStimulus(16'h0008);
    for (int t = 1; t <= 46; t++) begin
      @(negedge clk);
      checkOutput("bounce_pre", {3'b000, pre}, 4'h0);
      checkOutput("bounce_key", key, lastKey);
      checkOutput("bounce_col", col, (t < 44) ? 4'b0111 : 4'b1110);
      applyStimulus(((t % 8) < 4 && t < 40) ? 16'h0008 : 16'h0000);
    end

    // Rows 1 and 3 low together on column 0.
    waitColEntry(0, "multi");
    applyStimulus(16'h1010);
    trackPress("multi", 4'h4, 20, '0, -1, 0);

    // Special key held while another row on the same column is pressed.
    waitColEntry(2, "special");
    applyStimulus(16'h4000);
    trackPress("special", 4'hE, 40, 16'h0040, 16, 2);

    // Reset during press debounce, key kept held through and after reset.
    waitColEntry(0, "rstPress");
    applyStimulus(16'h0010);
    repeat (6) @(negedge clk);
    checkOutput("rstPress_prePre", {3'b000, pre}, 4'h0);
    midReset("rstPressAbort");
    trackPress("rstPress", 4'h4, 16, '0, -1, 0);

    // Reset while held, key kept held through and after reset.
    waitColEntry(0, "rstHeld");
    applyStimulus(16'h0100);
    repeat (14) @(negedge clk);
    checkOutput("rstHeld_preHigh", {3'b000, pre}, 4'h1);
    checkOutput("rstHeld_keyHeld", key, 4'h8);
    midReset("rstHeldAbort");
    trackPress("rstHeld", 4'h8, 20, '0, -1, 0);

    // Random single-key presses with random hold times.
    for (int i = 0; i < 6; i++) begin
      k   = int'($urandom_range(0, 15));
      rel = int'($urandom_range(13, 32));
      waitColEntry(k % 4, "rand");
      m = '0;
      m[k] = 1'b1;
      applyStimulus(m);
      trackPress("rand", k[3:0], rel, '0, -1, k % 4);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
